note_tone_gen: RTL

- Downstream stage of the piano controller, in the clk_1M domain.
- Accepts a registered {octave, note} code with a one-cycle valid strobe, whether live-played or from playback.
- Produces a 1-bit square-wave tone at the musical pitch, plus an activity flag, for the amplifier.
- Each note sounds for a fixed gate time, or until it is stopped or retriggered.

---
 rtl/note_tone_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave tone generator for the piano controller.
// A {octave, note} strobe starts, retriggers or stops a gated note at musical pitch.
`default_nettype none

module note_tone_gen #(
  parameter int NOTE_LEN = 250000,
  parameter bit SUSTAIN  = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic       clk_1M,
  input  logic       rst,
  input  logic       note_valid,
  input  logic [2:0] octave,
  input  logic [2:0] note,
  output logic       tone_out,
  output logic       active,
  output logic [5:0] cur_code
);

  localparam int GATE_W = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(NOTE_LEN - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t             state, state_n;
  logic               tone_n;
  logic [5:0]         code_n;
  logic [CNT_W-1:0]   half_reg, half_reg_n;
  logic [CNT_W-1:0]   half_cnt, half_cnt_n;
  logic [GATE_W-1:0]  gate_cnt, gate_cnt_n;
  logic [31:0]        base;
  logic [31:0]        scaled;
  logic               is_start;

  // Octave-4 half periods in clk_1M cycles; other octaves are power-of-two shifts.
  always_comb begin
    base = 32'd0;
    case (note)
      3'd1: base = 32'd1911;
      3'd2: base = 32'd1703;
      3'd3: base = 32'd1517;
      3'd4: base = 32'd1432;
      3'd5: base = 32'd1276;
      3'd6: base = 32'd1136;
      3'd7: base = 32'd1012;
      default: base = 32'd0;
    endcase
    if (octave < 3'd4) scaled = base << (3'd4 - octave);
    else               scaled = base >> (octave - 3'd4);
  end

  assign is_start = (octave != 3'd0) && (note != 3'd0);

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      state    <= IDLE;
      tone_out <= 1'b0;
      cur_code <= 6'd0;
      half_reg <= '0;
      half_cnt <= '0;
      gate_cnt <= '0;
    end else begin
      state    <= state_n;
      tone_out <= tone_n;
      cur_code <= code_n;
      half_reg <= half_reg_n;
      half_cnt <= half_cnt_n;
      gate_cnt <= gate_cnt_n;
    end
  end

  // A strobe overrides any timeout or toggle due on the same edge.
  always_comb begin
    state_n    = state;
    tone_n     = tone_out;
    code_n     = cur_code;
    half_reg_n = half_reg;
    half_cnt_n = half_cnt;
    gate_cnt_n = gate_cnt;
    if (note_valid) begin
      half_cnt_n = '0;
      gate_cnt_n = '0;
      if (is_start) begin
        state_n    = PLAY;
        tone_n     = 1'b1;
        code_n     = {octave, note};
        half_reg_n = CNT_W'(scaled);
      end else begin
        state_n = IDLE;
        tone_n  = 1'b0;
        code_n  = 6'd0;
      end
    end else if (state == PLAY) begin
      if (!SUSTAIN && (gate_cnt == GATE_LAST)) begin
        state_n    = IDLE;
        tone_n     = 1'b0;
        code_n     = 6'd0;
        half_cnt_n = '0;
        gate_cnt_n = '0;
      end else begin
        gate_cnt_n = SUSTAIN ? '0 : gate_cnt + GATE_W'(1);
        if (half_cnt == half_reg - CNT_W'(1)) begin
          tone_n     = ~tone_out;
          half_cnt_n = '0;
        end else begin
          half_cnt_n = half_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign active = (state == PLAY);

endmodule

`default_nettype wire
